// File: rtl/bcd_display_driver_if.sv
// Bus between the calculator core and the BCD display driver: the operand and
// request strobes flow in, the conversion status, result and segments flow out.
interface bcd_display_driver_if;
  logic [8:0]  value;
  logic        convert;
  logic        enable;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;

  // Calculator side: drives the operand and strobes, observes the display.
  modport master (
    output value, convert, enable,
    input  busy, done, bcd, HEX0, HEX1, HEX2
  );

  // Display driver side.
  modport slave (
    input  value, convert, enable,
    output busy, done, bcd, HEX0, HEX1, HEX2
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display driver: a one-bit-per-clock double-dabble engine
// converts the operand into three BCD digits, which are then decoded onto
// three active-low 7-segment digits with optional leading-zero blanking.
// A request arriving while a conversion runs is parked (last value wins) and
// started straight out of the DONE cycle so busy never drops in between.
module bcd_display_driver #(
  parameter int WIDTH       = 9,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input logic                 CLOCK_50,
  input logic                 reset_n,
  bcd_display_driver_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pending;
  logic [11:0]      r_scratch;
  logic [11:0]      r_bcd;
  logic [3:0]       r_cnt;

  logic [WIDTH-1:0] w_value;
  logic [WIDTH-1:0] w_load_val;
  logic [11:0]      w_adj;
  logic [11:0]      w_scratch_shifted;
  logic             w_busy;
  logic             w_done;
  logic [2:0]       w_blank;
  logic [6:0]       w_hex [3];

  assign w_value = bus.value[WIDTH-1:0];

  // Out of DONE a fresh request takes priority over the parked one, since it
  // carries the most recent operand.
  assign w_load_val = bus.convert ? w_value : r_pend_val;

  // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5) ?
                                (r_scratch[gi*4 +: 4] + 4'd3) :
                                r_scratch[gi*4 +: 4];
    end
  endgenerate

  assign w_scratch_shifted = {w_adj[10:0], r_bin[WIDTH-1]};

  // Next-state and status decode.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.convert) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == 4'd1) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = (bus.convert || r_pending) ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register plus the conversion datapath and parked-request capture.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_pend_val <= '0;
      r_pending  <= 1'b0;
      r_scratch  <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.convert) begin
            r_bin     <= w_value;
            r_scratch <= '0;
            r_cnt     <= CNT_LOAD;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scratch_shifted;
          r_bin     <= r_bin << 1;
          r_cnt     <= r_cnt - 4'd1;
          // The last shift lands directly in bcd so it is visible in DONE.
          if (r_cnt == 4'd1) r_bcd <= w_scratch_shifted;
          if (bus.convert) begin
            r_pending  <= 1'b1;
            r_pend_val <= w_value;
          end
        end
        S_DONE: begin
          // Loading is harmless when heading back to IDLE, so do it always.
          r_pending <= 1'b0;
          r_bin     <= w_load_val;
          r_scratch <= '0;
          r_cnt     <= CNT_LOAD;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Units are always shown; tens hide only when hundreds are also zero.
  assign w_blank[0] = !bus.enable;
  assign w_blank[1] = !bus.enable || (LZ_SUPPRESS && (r_bcd[11:4] == 8'd0));
  assign w_blank[2] = !bus.enable || (LZ_SUPPRESS && (r_bcd[11:8] == 4'd0));

  generate
    for (gi = 0; gi < 3; gi++) begin : g_seg
      assign w_hex[gi] = w_blank[gi] ? 7'b1111111 : seg7(r_bcd[gi*4 +: 4]);
    end
  endgenerate

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.bcd  = r_bcd;
  assign bus.HEX0 = w_hex[0];
  assign bus.HEX1 = w_hex[1];
  assign bus.HEX2 = w_hex[2];

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
Downstream stage of the calculator datapath. Consumes the 9-bit binary result `value` and a conversion strobe. It converts the value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It drives three active-low 7-segment digits (HEX2 = hundreds, HEX1 = tens, HEX0 = units), with leading-zero suppression and a global blank controlled by the calculator on/off flag.

Parameters:
WIDTH, 9, binary input width; legal 4..9, so the result always fits in 3 BCD digits.
LZ_SUPPRESS, 1, 1 = blank leading zero digits; 0 = always show all three digits.

Ports:
CLOCK_50  in  1  system clock, 50 MHz; all state changes on its rising edge.
reset_n   in  1  synchronous reset, active-low; sampled on the rising edge of CLOCK_50.
value     in  9  binary operand; only bits [WIDTH-1:0] are used, upper bits are ignored.
convert   in  1  conversion request; sampled every cycle while high (level-sampled, not edge-detected).
enable    in  1  display on; 0 blanks all digits.
busy      out 1  conversion in progress.
done      out 1  one-cycle pulse; `bcd` is updated in the same cycle.
bcd       out 12 registered result {hundreds, tens, units}, 4 bits each.
HEX0      out 7  units segments, active-low, bit order gfedcba (bit0 = a).
HEX1      out 7  tens segments, same encoding.
HEX2      out 7  hundreds segments, same encoding.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; busy=0, done=0, bcd=12'h000.
  - Pending flag and iteration counter cleared; scratch registers cleared.
  - Reset in the middle of a conversion aborts it; any pending request is dropped.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - convert=1 → latch value[WIDTH-1:0] into the binary shift register, clear the 12-bit scratch, load counter=WIDTH, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each cycle, one step of double-dabble:
  - every scratch nibble ≥5 gets +3;
  - then {scratch, bin} shifts left by 1;
  - counter decrements by 1.
  - After WIDTH SHIFT cycles, go to DONE.
- DONE (exactly one cycle):
  - bcd ← scratch; done=1.
  - If pending=1: clear pending, latch the pending value, reload counter=WIDTH, go directly to SHIFT.
  - Else go to IDLE.
- busy:
  - 1 in SHIFT and DONE, 0 in IDLE.
  - During back-to-back conversions, busy stays 1 continuously.
- Latency: convert sampled at edge N → done=1 and new bcd visible during cycle N+WIDTH+1 (cycle N+10 for WIDTH=9).
- Convert while busy (SHIFT or DONE):
  - set pending and capture value into the pending register;
  - multiple requests collapse to one, last value wins;
  - the conversion in flight is never disturbed.
- bcd holds its value between conversions; it changes only in DONE or on reset.
- Segment decode:
  - combinational from the registered bcd and enable;
  - digits 0-9: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - blank = 1111111.
- Blanking:
  - enable=0 → all three HEX = 1111111; conversion still runs and bcd still updates.
  - LZ_SUPPRESS=1: HEX2 blank when hundreds=0; HEX1 blank when hundreds=0 and tens=0; HEX0 always displayed.
- Boundaries:
  - value=0 → bcd=000.
  - value=511 → bcd=511, no overflow possible.
  - Nibble values >9 never appear in bcd.

Test Plan:
1. Reset, then enable=1, no convert → bcd=000, busy=0, HEX0=1000000, HEX1=HEX2=1111111.
2. value=511, convert pulse at edge N → busy=1 from N+1; done=1 and bcd=12'h511 at N+10; HEX2=0010010, HEX1=1111001, HEX0=1111001; busy=0 at N+11.
3. value=105 → bcd=12'h105; HEX1=1000000 (interior zero shown). value=7 → HEX2 and HEX1 blank, HEX0=1111000.
4. Convert with value=42, then at N+3 convert with value=88 and at N+5 with value=300 → first done shows bcd=042; busy stays high; second done at N+20 shows bcd=300; 88 is never output.
5. Start converting 511, assert reset_n=0 at N+4 → next cycle bcd=000, busy=0, no done pulse; a later convert of 63 gives bcd=063.
6. bcd=123 with enable toggled 1→0→1 → all HEX=1111111 while enable=0, digits restored immediately after, bcd unchanged throughout.
